load_unit: RTL and testbench
============================

# load_unit

Multi-cycle load path between the execute stage and data memory; the read-side counterpart of the store-data formatter. It accepts one RV32I load (LB/LH/LW/LBU/LHU), issues word-aligned reads to data memory, aligns and sign/zero-extends the result, and returns it with the destination register tag. It supports one outstanding request. Loads that span two words are optionally split into two reads.

## Interface
Parameters:
- `XLEN`, 32: data/address width (only 32 is supported).

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  1  — load request present.
- `req_ready`  out  1  — unit can accept a request (high only in IDLE).
- `opcode`  in  7  — instruction opcode; a load is 7'b0000011.
- `funct3`  in  3  — load width/sign select.
- `addr`  in  32  — byte address (rs1 + imm).
- `rd`  in  5  — destination tag, passed through.
- `mem_rd_en`  out  1  — word read request, held until the response arrives.
- `mem_addr`  out  32  — word-aligned read address; bits [1:0] are always 0.
- `mem_rvalid`  in  1  — read data valid, one cycle per read.
- `mem_rdata`  in  32  — read word, little-endian.
- `resp_valid`  out  1  — one-cycle result strobe.
- `resp_data`  out  32  — extended load result.
- `resp_rd`  out  5  — latched `rd`.
- `resp_fault`  out  1  — illegal load or misaligned load (misaligned only when splitting is disabled).

## Operation
- States: IDLE, WAIT0, WAIT1, RESP.
- **IDLE:** `req_ready`=1. A handshake (`req_valid` & `req_ready`) latches `opcode`, `funct3`, `addr` and `rd`.
  - Legal load → WAIT0.
  - Otherwise → RESP with fault set.
- Illegal request: opcode is not 0000011, or funct3 is 011, 110 or 111.
- **WAIT0:** `mem_rd_en`=1, `mem_addr`={addr[31:2],2'b00}. On `mem_rvalid`, capture word0.
  - Access spans two words (LH with offset 3; LW with offset 1–3) → WAIT1.
  - Otherwise → RESP.
- **WAIT1:** `mem_rd_en`=1, `mem_addr`={addr[31:2],2'b00}+4. Address wraps modulo 2^32. On `mem_rvalid`, capture word1 → RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle, then → IDLE.
- Data formation:
  - Shift {word1,word0} (64 bits; word1=0 if unused) right by addr[1:0]×8.
  - Take the low 8, 16 or 32 bits.
  - funct3 000/001 sign-extend; 100/101 zero-extend; 010 passes the word.
- Fault response: `resp_data`=0, `resp_fault`=1, and no memory access is made.
- `mem_rvalid` is ignored outside WAIT0 and WAIT1.
- Reset in any state:
  - Next state is IDLE, `mem_rd_en` drops, and any in-flight read is discarded.
  - A late `mem_rvalid` is ignored.
- Reset values: `req_ready`=1 (IDLE), `mem_rd_en`=0, `mem_addr`=0, `resp_valid`=0, `resp_data`=0, `resp_rd`=0, `resp_fault`=0.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- Aligned load, with `mem_rvalid` in the first WAIT0 cycle: accept at edge N, `mem_rd_en` high in cycle N+1, `resp_valid` in cycle N+2. Total latency 2 cycles.
- Split load: 3 cycles minimum. Each memory wait cycle adds one.
- Fault: `resp_valid` in cycle N+1.
- Back-to-back: the next request is accepted in the cycle after RESP, because IDLE is re-entered.
- `resp_data`, `resp_rd` and `resp_fault` hold their values until the next RESP.

## Configuration
- `LOAD_MISALIGNED_EN`
  - Defined: spanning loads take the WAIT1 path and return correct data.
  - Undefined: WAIT1 is not compiled. Any misaligned load (LH/LHU with addr[0]=1; LW with addr[1:0]≠0) is treated as a fault: no memory read, RESP with `resp_fault`=1 and `resp_data`=0.

## Structure
- Package `load_pkg` holds:
  - `OP_LOAD`;
  - the funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`;
  - the state enum `load_state_t`.
- Sub-module `load_extract` is purely combinational: word0, word1, offset and funct3 in; aligned, extended 32-bit value out. The FSM lives in `load_unit`.

## Test plan
Memory holds 0x100=0x8C3DD467 and 0x104=0x11223344, with a 0-wait response.

- LB @0x101 → `resp_data`=0xFFFFFFD4; LBU @0x101 → 0x000000D4; one read to 0x100 in each case.
- LH @0x102 → 0xFFFF8C3D; LHU @0x102 → 0x00008C3D; LW @0x100 → 0x8C3DD467. `resp_valid` appears 2 cycles after accept.
- LW @0x103 (macro defined) → reads 0x100 then 0x104, `resp_data`=0x2233448C, latency 3. With the macro undefined: `resp_fault`=1, data 0, no `mem_rd_en`.
- opcode 0100011, or funct3=011 → no memory access; `resp_fault`=1 and `resp_valid` in cycle N+1.
- Memory stalls 3 cycles on LB @0x100 → `mem_rd_en` held with a stable address, then `resp_data`=0x00000067 and `resp_rd` equals the latched `rd`.
- `rst` asserted in WAIT0, followed by a stray `mem_rvalid` → IDLE, no `resp_valid`, all outputs at reset values; the next request completes normally.

Source files
------------

// File: rtl/load_pkg.sv
// Shared definitions for the RV32I load path: opcode/funct3 constants,
// the load FSM state type and small decode helpers used by load_unit.
// Purely declarative; no logic, latency or backpressure of its own.
package load_pkg;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        WAIT1 = 2'd2,
        RESP  = 2'd3
    } load_state_t;

    // A legal request is a load opcode with one of the five defined widths.
    function automatic logic load_legal(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_LOAD) &&
               ((f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                (f3 == F3_LBU) || (f3 == F3_LHU));
    endfunction

    // Access crosses into the next word and needs a second read.
    function automatic logic load_spans(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == F3_LW)
            return off != 2'd0;
        if ((f3 == F3_LH) || (f3 == F3_LHU))
            return off == 2'd3;
        return 1'b0;
    endfunction

    // Access is not naturally aligned to its own size.
    function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == F3_LW)
            return off != 2'd0;
        if ((f3 == F3_LH) || (f3 == F3_LHU))
            return off[0];
        return 1'b0;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Aligns a byte/half/word out of a {word1,word0} pair and sign/zero-extends it.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   word0  - word at the load's aligned address
//   word1  - following word (zero when the load fits in word0)
//   offset - byte offset addr[1:0]
//   funct3 - load width/sign select
//   data   - aligned, extended result
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word0,
    input  logic [XLEN-1:0] word1,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] win;

    // Shifting the 64-bit little-endian pair by whole bytes brings the
    // addressed byte to bit 0; bytes above the window are never needed.
    assign win = XLEN'({word1, word0} >> {offset, 3'b000});

    always_comb begin
        data = win;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){win[7]}}, win[7:0]};
            F3_LH:   data = {{(XLEN-16){win[15]}}, win[15:0]};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, win[7:0]};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, win[15:0]};
            default: data = win;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// RV32I load unit: word-aligned memory reads, byte alignment and extension.
// Latency: aligned 2 cycles, spanning 3 cycles, fault 1 cycle, +1 per memory wait.
// Backpressure: one request outstanding; req_ready high only while IDLE.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   req_valid/req_ready           - request handshake
//   opcode, funct3, addr, rd      - load instruction fields (latched on accept)
//   mem_rd_en, mem_addr           - word read request, held until mem_rvalid
//   mem_rvalid, mem_rdata         - read response, one cycle per read
//   resp_valid                    - one-cycle result strobe
//   resp_data, resp_rd, resp_fault- result, held until the next response
//
// Build option: LOAD_MISALIGNED_EN -- when defined, loads that cross a word
// boundary are split into two reads; otherwise misaligned loads fault.
module load_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [4:0]      rd,
    output logic            mem_rd_en,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            resp_fault
);

    import load_pkg::*;

    load_state_t     state;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] ext_word0;
    logic [XLEN-1:0] ext_word1;
    logic [XLEN-1:0] ext_data;
    logic            req_fault;
    logic            split_needed;

`ifdef LOAD_MISALIGNED_EN
    logic [XLEN-1:0] word0_q;

    // In WAIT1 the first word comes from the holding register and the
    // live bus supplies the second; in WAIT0 the bus is the first word.
    assign ext_word0    = (state == WAIT1) ? word0_q : mem_rdata;
    assign ext_word1    = (state == WAIT1) ? mem_rdata : '0;
    assign req_fault    = !load_legal(opcode, funct3);
    assign split_needed = load_spans(f3_q, off_q);
`else
    assign ext_word0    = mem_rdata;
    assign ext_word1    = '0;
    assign req_fault    = !load_legal(opcode, funct3) || load_misaligned(funct3, addr[1:0]);
    assign split_needed = 1'b0;
`endif

    load_extract #(.XLEN(XLEN)) u_extract (
        .word0  (ext_word0),
        .word1  (ext_word1),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    // Decoded straight from the state register, so no input reaches them.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            f3_q       <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_fault <= 1'b0;
`ifdef LOAD_MISALIGNED_EN
            word0_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q  <= funct3;
                        off_q <= addr[1:0];
                        rd_q  <= rd;
                        if (req_fault) begin
                            // Faults skip memory entirely and answer next cycle.
                            state      <= RESP;
                            resp_data  <= '0;
                            resp_rd    <= rd;
                            resp_fault <= 1'b1;
                        end else begin
                            state     <= WAIT0;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= {addr[XLEN-1:2], 2'b00};
                        end
                    end
                end

                WAIT0: begin
                    if (mem_rvalid) begin
                        if (split_needed) begin
`ifdef LOAD_MISALIGNED_EN
                            word0_q  <= mem_rdata;
                            mem_addr <= mem_addr + XLEN'(4);
                            state    <= WAIT1;
`endif
                        end else begin
                            mem_rd_en  <= 1'b0;
                            state      <= RESP;
                            resp_data  <= ext_data;
                            resp_rd    <= rd_q;
                            resp_fault <= 1'b0;
                        end
                    end
                end

`ifdef LOAD_MISALIGNED_EN
                WAIT1: begin
                    if (mem_rvalid) begin
                        mem_rd_en  <= 1'b0;
                        state      <= RESP;
                        resp_data  <= ext_data;
                        resp_rd    <= rd_q;
                        resp_fault <= 1'b0;
                    end
                end
`endif

                RESP: state <= IDLE;

                default: begin
                    state     <= IDLE;
                    mem_rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Randomized self-checking bench for load_unit against a byte-level load model.
// Latency: n/a (testbench).
// Backpressure: memory responder inserts a programmable number of wait cycles.
module tb_load_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fault;

    int checks   = 0;
    int failures = 0;

    int          stall    = 0;
    logic        stray_rv = 1'b0;
    logic [31:0] rd_log[$];
    bit          busy     = 1'b0;
    int          cnt      = 0;

    load_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .addr       (addr),
        .rd         (rd),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_fault (resp_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Memory contents: two fixed words from the test plan, hash elsewhere.
    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a == 32'h100) return 32'h8C3DD467;
        if (a == 32'h104) return 32'h11223344;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [7:0] memb(input logic [31:0] a);
        logic [31:0] w;
        w = memw({a[31:2], 2'b00});
        return 8'(w >> (8 * a[1:0]));
    endfunction

    // Reference: gathers bytes one at a time and extends by width/sign rules.
    task automatic ref_load(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                            output logic [31:0] d, output logic f, output int nrd);
        int          size;
        logic        legal;
        logic [31:0] v;
        legal = (op == 7'b0000011) &&
                (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        f     = !legal;
`ifndef LOAD_MISALIGNED_EN
        if (legal && (int'(a[1:0]) % size) != 0) f = 1'b1;
`endif
        d   = '0;
        nrd = 0;
        if (!f) begin
            v = '0;
            for (int i = 0; i < size; i++)
                v = v | (32'(memb(a + 32'(i))) << (8 * i));
            if (f3[2] == 1'b0 && size < 4 && v[8 * size - 1])
                v = v | ~((32'h1 << (8 * size)) - 32'h1);
            d   = v;
            nrd = (int'(a[1:0]) + size > 4) ? 2 : 1;
        end
    endtask

    // Memory responder: logs each new read, answers after `stall` waits.
    always @(posedge clk) begin
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEADBEEF;
        if (stray_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hA5A5A5A5;
        end else if (mem_rd_en) begin
            if (!busy) begin
                busy = 1'b1;
                cnt  = stall;
                rd_log.push_back(mem_addr);
            end
            if (cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = memw(mem_addr);
                busy       = 1'b0;
            end else begin
                cnt--;
            end
        end else begin
            busy = 1'b0;
        end
    end

    // Issue one request at a negedge and check the full transaction.
    task automatic do_load(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] r, input int st);
        logic [31:0] exp_d;
        logic        exp_f;
        int          nrd;
        int          base;
        int          lat;
        int          rden_cyc;
        int          n;
        bit          seen;
        logic [31:0] a0;
        ref_load(op, f3, a, exp_d, exp_f, nrd);
        a0    = {a[31:2], 2'b00};
        stall = st;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready", 32'(req_ready), 32'd1);
        base      = rd_log.size();
        req_valid = 1'b1;
        opcode    = op;
        funct3    = f3;
        addr      = a;
        rd        = r;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        opcode    = 7'($urandom);
        funct3    = 3'($urandom);
        addr      = $urandom;
        rd        = 5'($urandom);
        lat       = 1;
        seen      = 1'b0;
        rden_cyc  = 0;
        while (!seen && lat <= 20) begin
            if (resp_valid) begin
                seen = 1'b1;
            end else begin
                if (mem_rd_en) begin
                    rden_cyc++;
                    if (rd_log.size() > base)
                        check_eq("mem_addr_stable", mem_addr, rd_log[rd_log.size() - 1]);
                    else
                        check_eq("mem_addr_logged", 32'(rd_log.size()), 32'(base + 1));
                end
                @(negedge clk);
                lat++;
            end
        end
        check_eq("resp_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(lat), exp_f ? 32'd1 : 32'(1 + nrd * (st + 1)));
        check_eq("resp_data", resp_data, exp_d);
        check_eq("resp_rd", 32'(resp_rd), 32'(r));
        check_eq("resp_fault", 32'(resp_fault), 32'(exp_f));
        check_eq("rd_en_cycles", 32'(rden_cyc), 32'(nrd * (st + 1)));
        check_eq("num_reads", 32'(rd_log.size() - base), 32'(nrd));
        if (rd_log.size() - base >= 1 && nrd >= 1) check_eq("read0_addr", rd_log[base], a0);
        if (rd_log.size() - base >= 2 && nrd >= 2) check_eq("read1_addr", rd_log[base + 1], a0 + 32'd4);
        @(negedge clk);
        check_eq("resp_one_cycle", 32'(resp_valid), 32'd0);
        check_eq("resp_data_hold", resp_data, exp_d);
        check_eq("idle_after_resp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        opcode     = '0;
        funct3     = '0;
        addr       = '0;
        rd         = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_data", resp_data, 32'd0);
        check_eq("rst_resp_rd", 32'(resp_rd), 32'd0);
        check_eq("rst_resp_fault", 32'(resp_fault), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed loads from the test plan.
        do_load(7'b0000011, 3'b000, 32'h101, 5'd1, 0);
        check_eq("lb_101", resp_data, 32'hFFFFFFD4);
        do_load(7'b0000011, 3'b100, 32'h101, 5'd2, 0);
        check_eq("lbu_101", resp_data, 32'h000000D4);
        do_load(7'b0000011, 3'b001, 32'h102, 5'd3, 0);
        check_eq("lh_102", resp_data, 32'hFFFF8C3D);
        do_load(7'b0000011, 3'b101, 32'h102, 5'd4, 0);
        check_eq("lhu_102", resp_data, 32'h00008C3D);
        do_load(7'b0000011, 3'b010, 32'h100, 5'd5, 0);
        check_eq("lw_100", resp_data, 32'h8C3DD467);
        do_load(7'b0000011, 3'b010, 32'h103, 5'd6, 0);
`ifdef LOAD_MISALIGNED_EN
        check_eq("lw_103", resp_data, 32'h2233448C);
`else
        check_eq("lw_103_fault", 32'(resp_fault), 32'd1);
`endif
        do_load(7'b0100011, 3'b010, 32'h100, 5'd7, 0);
        check_eq("store_op_fault", 32'(resp_fault), 32'd1);
        do_load(7'b0000011, 3'b011, 32'h100, 5'd8, 0);
        do_load(7'b0000011, 3'b110, 32'h104, 5'd9, 1);
        do_load(7'b0000011, 3'b000, 32'h100, 5'd13, 3);
        check_eq("lb_stall", resp_data, 32'h00000067);
        do_load(7'b0000011, 3'b010, 32'hFFFFFFFE, 5'd14, 1);
        do_load(7'b0000011, 3'b001, 32'hFFFFFFFF, 5'd15, 0);
        do_load(7'b0000011, 3'b101, 32'h105, 5'd16, 2);

        // Reset while a read is outstanding, then a stray read response.
        stall     = 5;
        req_valid = 1'b1;
        opcode    = 7'b0000011;
        funct3    = 3'b000;
        addr      = 32'h100;
        rd        = 5'd21;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("pre_rst_rd_en", 32'(mem_rd_en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        stray_rv = 1'b1;
        check_eq("rst_drop_rd_en", 32'(mem_rd_en), 32'd0);
        @(negedge clk);
        stray_rv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("stray_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        check_eq("post_rst_ready", 32'(req_ready), 32'd1);
        check_eq("post_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("post_rst_addr", mem_addr, 32'd0);
        check_eq("post_rst_data", resp_data, 32'd0);
        check_eq("post_rst_rd", 32'(resp_rd), 32'd0);
        check_eq("post_rst_fault", 32'(resp_fault), 32'd0);
        do_load(7'b0000011, 3'b000, 32'h100, 5'd22, 0);
        check_eq("after_rst_lb", resp_data, 32'h00000067);

        // Randomized loads around the fixed words and the address wrap.
        for (int k = 0; k < 150; k++) begin
            logic [6:0]  op;
            logic [31:0] a;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'b0000011;
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                            : 32'h100 + 32'($urandom_range(0, 63));
            do_load(op, 3'($urandom), a, 5'($urandom), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
